// File: rtl/fir_stream_adapter.sv
// Streams samples into a frame-based FIR: FIFO-buffered input, one filter sample per FRAME_LEN strobes.
// Latency: m_valid rises 2 clocks after the boundary strobe; s_ready drops only when the FIFO is full.
// Backpressure: a busy output stalls the filter at the frame boundary. FIR_ADAPT_STALL_CNT_EN adds a stall counter.
module fir_stream_adapter #(
    parameter int WIDTH      = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] fir_sig,
    output logic                    fir_ready,
    input  logic signed [WIDTH-1:0] fir_result,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [15:0]             stall_cnt
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_OUT} state_t;

    logic signed [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CNTW-1:0]         r_count;
    logic [CW-1:0]           r_cnt;
    state_t                  r_state;
    logic                    r_cap_pend;
    logic                    r_prime;
    logic signed [WIDTH-1:0] r_m_data;
    logic                    r_m_valid;

    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fir_ready;
    logic [CW-1:0]           w_cnt_nxt;
    logic [CNTW-1:0]         w_count_nxt;
    state_t                  w_state_nxt;

    assign w_empty   = (r_count == '0);
    assign s_ready   = rst_n && (r_count < CNTW'(FIFO_DEPTH));
    assign w_push    = s_valid && s_ready;
    assign fir_sig   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fir_ready = w_fir_ready;
    assign m_data    = r_m_data;
    assign m_valid   = r_m_valid;

    // State is chosen from the next cnt and FIFO fill so it always describes the cycle it is in.
    always_comb begin
        w_fir_ready = 1'b0;
        w_pop       = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        case (r_state)
            RUN:      w_fir_ready = 1'b1;
            WAIT_OUT: w_fir_ready = !r_m_valid && !r_cap_pend;
            default:  w_fir_ready = 1'b0;
        endcase
        w_pop = w_fir_ready && (r_cnt == LAST);
        if (w_fir_ready) begin
            w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
        w_count_nxt = r_count + CNTW'(w_push) - CNTW'(w_pop);
        if (w_cnt_nxt != LAST) begin
            w_state_nxt = RUN;
        end else if (w_count_nxt == '0) begin
            w_state_nxt = IDLE;
        end else begin
            w_state_nxt = WAIT_OUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= LAST;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // The filter result is valid the cycle after its boundary strobe; the first one after reset is stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_pend <= 1'b0;
            r_prime    <= 1'b1;
            r_m_data   <= '0;
            r_m_valid  <= 1'b0;
        end else begin
            r_cap_pend <= w_pop;
            if (r_cap_pend) begin
                if (r_prime) begin
                    r_prime <= 1'b0;
                end else begin
                    r_m_data  <= fir_result;
                    r_m_valid <= 1'b1;
                end
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef FIR_ADAPT_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if ((r_cnt == LAST) && !w_empty && !w_fir_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fir_stream_adapter.sv
// Bench for fir_stream_adapter: a stand-in 4-sample averaging filter, a queue-based model and directed scenarios.
module tb_fir_stream_adapter;
    localparam int W = 20;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic signed [W-1:0] s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] fir_sig;
    logic                fir_ready;
    logic signed [W-1:0] fir_result;
    logic signed [W-1:0] m_data;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic [15:0]         stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_stream_adapter #(.WIDTH(W), .FIFO_DEPTH(D), .FRAME_LEN(128)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .fir_sig(fir_sig), .fir_ready(fir_ready), .fir_result(fir_result),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .stall_cnt(stall_cnt)
    );

    // Stand-in filter: at its index-127 strobe it outputs the mean of the 4 previously latched samples.
    logic [6:0] f_idx;
    int         f_h [4];
    int         f_out;
    assign fir_result = f_out[W-1:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_idx <= 7'd127;
            f_out <= 0;
            for (int i = 0; i < 4; i++) f_h[i] <= 0;
        end else if (fir_ready) begin
            f_idx <= f_idx + 7'd1;
            if (f_idx == 7'd127) begin
                f_out  <= (f_h[0] + f_h[1] + f_h[2] + f_h[3]) / 4;
                f_h[0] <= int'(fir_sig);
                f_h[1] <= f_h[0];
                f_h[2] <= f_h[1];
                f_h[3] <= f_h[2];
            end
        end
    end

    // Model: samples in a queue, a frame position, and the popped-sample history the filter has seen.
    int q[$];
    int popped[$];
    int mcnt = 127;
    bit mv = 0, pend = 0, prime = 1;
    int md = 0, pend_val = 0, stalls = 0;
    bit m_fr, m_push, m_strobe;

    function automatic bit exp_fir_ready();
        return (mcnt != 127) || (q.size() > 0 && !mv && !pend);
    endfunction

    function automatic int mean_last4();
        int s = 0;
        for (int i = 0; i < 4; i++) if (popped.size() > i) s += popped[popped.size() - 1 - i];
        return s / 4;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            popped.delete();
            mcnt = 127; mv = 0; md = 0; pend = 0; prime = 1; stalls = 0;
        end else begin
            m_fr     = exp_fir_ready();
            m_push   = s_valid && (q.size() < D);
            m_strobe = m_fr && (mcnt == 127);
            if (mcnt == 127 && q.size() > 0 && !m_fr && stalls < 65535) stalls++;
            if (pend) begin
                pend = 0;
                if (prime) prime = 0;
                else begin mv = 1; md = pend_val; end
            end else if (mv && m_ready) begin
                mv = 0;
            end
            if (m_strobe) begin
                pend_val = mean_last4();
                popped.push_back(q.pop_front());
                pend = 1;
            end
            if (m_push) q.push_back(int'(s_data));
            if (m_fr) mcnt = (mcnt + 1) % 128;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison plus boundary / m_valid-rise bookkeeping for the directed checks.
    int n_bnd = 0, n_strobe = 0, n_mv_rise = 0, mv_rise_cyc = 0;
    int bnd_cyc [8];
    int bnd_strobes [8];
    bit mv_prev = 0;

    always @(negedge clk) begin
        check("s_ready", int'(s_ready), int'(rst_n && q.size() < D));
        check("fir_ready", int'(fir_ready), int'(exp_fir_ready()));
        check("fir_sig", int'(fir_sig), (q.size() > 0) ? q[0] : 0);
        check("m_valid", int'(m_valid), int'(mv));
        if (mv) check("m_data", int'(m_data), md);
`ifdef FIR_ADAPT_STALL_CNT_EN
        check("stall_cnt", int'(stall_cnt), stalls);
`else
        check("stall_cnt", int'(stall_cnt), 0);
`endif
        if (rst_n && fir_ready && f_idx == 7'd127) begin
            if (n_bnd < 8) begin
                bnd_cyc[n_bnd]     = cyc;
                bnd_strobes[n_bnd] = n_strobe;
            end
            n_bnd++;
        end
        if (rst_n && fir_ready) n_strobe++;
        if (m_valid && !mv_prev) begin
            n_mv_rise++;
            mv_rise_cyc = cyc;
        end
        mv_prev = m_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int acc_cyc = 0;

    task automatic push(input int v);
        bit done;
        done    = 0;
        s_data  = v[W-1:0];
        s_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                acc_cyc = cyc;
                done    = 1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic wait_rise(input int base, input int budget);
        for (int i = 0; i < budget && n_mv_rise <= base; i++) tick();
        if (n_mv_rise <= base) check("rise_timeout", n_mv_rise, base + 1);
    endtask

    int base_rise, base_bnd;

    initial begin
        // Reset state.
        repeat (3) tick();
        @(negedge clk);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_fir_ready", int'(fir_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        #1;
        rst_n = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("idle_fir_ready", int'(fir_ready), 0);
        check("idle_s_ready", int'(s_ready), 1);
        check("idle_m_valid", int'(m_valid), 0);
        tick();

        // Two samples back to back: first result discarded, second is mean(1000) = 250.
        base_rise = n_mv_rise;
        push(1000);
        push(-2000);
        wait_rise(base_rise, 400);
        check("rises_after_2_bnd", n_mv_rise - base_rise, 1);
        check("strobes_between_bnd", bnd_strobes[1] - bnd_strobes[0] - 1, 127);
        check("latency", mv_rise_cyc - bnd_cyc[1], 2);
        check("first_result", int'(m_data), 250);

        // Fill the FIFO mid-frame; the fifth sample goes in the cycle after the next boundary.
        push(11); push(22); push(33); push(44);
        @(negedge clk);
        check("full_s_ready", int'(s_ready), 0);
        #1;
        push(55);
        check("refill_after_pop", acc_cyc - bnd_cyc[2], 1);

        // Output held off: mean(1000,-2000) = -250 must stay put while the boundary stalls.
        m_ready = 1'b0;
        repeat (300) tick();
        check("held_m_valid", int'(m_valid), 1);
        check("held_m_data", int'(m_data), -250);
        check("stalled_fir_ready", int'(fir_ready), 0);
`ifdef FIR_ADAPT_STALL_CNT_EN
        check("stall_cnt_counting", int'(stall_cnt > 16'd100), 1);
`else
        check("stall_cnt_zero", int'(stall_cnt), 0);
`endif
        m_ready = 1'b1;

        // Reset mid-frame with 33, 44, 55 queued.
        for (int i = 0; i < 300 && mcnt != 40; i++) tick();
        check("reached_cnt40", mcnt, 40);
        check("head_before_rst", int'(fir_sig), 33);
        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("mid_rst_fir_sig", int'(fir_sig), 0);
        check("mid_rst_m_data", int'(m_data), 0);
        check("mid_rst_s_ready", int'(s_ready), 0);
        check("mid_rst_stall", int'(stall_cnt), 0);
        #1;
        rst_n = 1'b1;
        tick();
        base_rise = n_mv_rise;
        push(3000);
        repeat (10) tick();
        check("primed_discard", n_mv_rise - base_rise, 0);
        push(4000);
        wait_rise(base_rise, 400);
        check("post_rst_result", int'(m_data), 750);

        // DC input for 200 frames.
        s_data   = 20'sd10000;
        s_valid  = 1'b1;
        base_bnd = n_bnd;
        for (int i = 0; i < 200 * 130 && n_bnd < base_bnd + 200; i++) tick();
        check("dc_frames", int'(n_bnd - base_bnd >= 200), 1);
        base_rise = n_mv_rise;
        wait_rise(base_rise, 400);
        check("dc_settled", int'(m_data >= 9800 && m_data <= 10200), 1);
        s_valid = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
